// File: rtl/ht_job_scheduler_if.sv
// Bundle of job, engine and result signals between the scheduler and its host/engine side.
// The slave modport is the scheduler; master is the SPI front-end plus the nonce engine.
interface ht_job_scheduler_if #(
  parameter int JOB_DEPTH = 4,
  parameter int ID_W      = 4
);
  logic                       job_valid;
  logic                       job_ready;
  logic [ID_W-1:0]            job_id;
  logic [95:0]                job_m_data;
  logic [255:0]               job_init_h;
  logic                       core_start;
  logic [ID_W-1:0]            core_id;
  logic [95:0]                core_m_data;
  logic [255:0]               core_init_h;
  logic                       core_busy;
  logic                       core_success;
  logic [31:0]                core_nonce;
  logic [ID_W-1:0]            core_hash_id;
  logic                       res_valid;
  logic [ID_W+31:0]           res_data;
  logic                       res_pop;
  logic                       flush;
  logic                       irq;
  logic                       res_overflow;
  logic                       dispatch_err;
  logic [$clog2(JOB_DEPTH):0] job_count;

  modport slave (
    input  job_valid, job_id, job_m_data, job_init_h,
    input  core_busy, core_success, core_nonce, core_hash_id,
    input  res_pop, flush,
    output job_ready, core_start, core_id, core_m_data, core_init_h,
    output res_valid, res_data, irq, res_overflow, dispatch_err, job_count
  );

  modport master (
    output job_valid, job_id, job_m_data, job_init_h,
    output core_busy, core_success, core_nonce, core_hash_id,
    output res_pop, flush,
    input  job_ready, core_start, core_id, core_m_data, core_init_h,
    input  res_valid, res_data, irq, res_overflow, dispatch_err, job_count
  );
endinterface

// File: rtl/ht_job_scheduler.sv
// Job queue front-end for the nonce engine: buffers jobs, dispatches one at a time,
// watches for a stalled engine and collects found nonces into a result queue.
module ht_job_scheduler #(
  parameter int JOB_DEPTH = 4,
  parameter int RES_DEPTH = 8,
  parameter int ID_W      = 4,
  parameter int BUSY_TMO  = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  ht_job_scheduler_if.slave    bus
);
  localparam int JA_W  = $clog2(JOB_DEPTH);
  localparam int JC_W  = JA_W + 1;
  localparam int RA_W  = $clog2(RES_DEPTH);
  localparam int RC_W  = RA_W + 1;
  localparam int JOB_W = ID_W + 96 + 256;
  localparam int RES_W = ID_W + 32;
  localparam int TMO_W = $clog2(BUSY_TMO + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, RUN} state_t;
  state_t state;

  logic [JOB_W-1:0] job_mem [JOB_DEPTH];
  logic [JA_W-1:0]  job_wr, job_rd;
  logic [JC_W-1:0]  job_cnt;
  logic             job_full, job_push, job_pop;

  logic [RES_W-1:0] res_mem [RES_DEPTH];
  logic [RA_W-1:0]  res_wr, res_rd;
  logic [RC_W-1:0]  res_cnt;
  logic             res_full, res_push, res_take;

  logic [TMO_W-1:0] tmo_cnt;

  assign job_full      = (job_cnt == JC_W'(JOB_DEPTH));
  assign bus.job_ready = !job_full && !bus.flush;
  assign job_push      = bus.job_valid && bus.job_ready;
  // The pop happens on the edge entering LAUNCH, so a flush on that edge suppresses the launch.
  assign job_pop       = (state == IDLE) && (job_cnt != '0) && !bus.flush;
  assign bus.job_count = job_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      job_wr  <= '0;
      job_rd  <= '0;
      job_cnt <= '0;
    end else if (bus.flush) begin
      job_wr  <= '0;
      job_rd  <= '0;
      job_cnt <= '0;
    end else begin
      if (job_push) job_wr <= job_wr + JA_W'(1);
      if (job_pop)  job_rd <= job_rd + JA_W'(1);
      case ({job_push, job_pop})
        2'b10:   job_cnt <= job_cnt + JC_W'(1);
        2'b01:   job_cnt <= job_cnt - JC_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (job_push) job_mem[job_wr] <= {bus.job_id, bus.job_m_data, bus.job_init_h};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      tmo_cnt          <= '0;
      bus.core_start   <= 1'b0;
      bus.dispatch_err <= 1'b0;
      bus.core_id      <= '0;
      bus.core_m_data  <= '0;
      bus.core_init_h  <= '0;
    end else begin
      bus.core_start   <= 1'b0;
      bus.dispatch_err <= 1'b0;
      case (state)
        IDLE: begin
          if (job_pop) begin
            state          <= LAUNCH;
            bus.core_start <= 1'b1;
            {bus.core_id, bus.core_m_data, bus.core_init_h} <= job_mem[job_rd];
          end
        end
        LAUNCH: begin
          state   <= WAIT_BUSY;
          tmo_cnt <= '0;
        end
        WAIT_BUSY: begin
          if (bus.core_busy) begin
            state <= RUN;
          end else if (tmo_cnt == TMO_W'(BUSY_TMO - 1)) begin
            // Engine never acknowledged: the job is abandoned.
            state            <= IDLE;
            bus.dispatch_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        RUN: begin
          if (!bus.core_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign res_full      = (res_cnt == RC_W'(RES_DEPTH));
  assign bus.res_valid = (res_cnt != '0);
  assign bus.res_data  = bus.res_valid ? res_mem[res_rd] : '0;
  assign res_take      = bus.res_pop && bus.res_valid && !bus.flush;
  // A flush empties the queue first, so a same-cycle result always finds room.
  assign res_push      = bus.core_success && (!res_full || res_take || bus.flush);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_wr           <= '0;
      res_rd           <= '0;
      res_cnt          <= '0;
      bus.res_overflow <= 1'b0;
      bus.irq          <= 1'b0;
    end else begin
      bus.irq <= bus.res_valid;
      if (bus.flush) begin
        res_rd           <= '0;
        res_wr           <= res_push ? RA_W'(1) : '0;
        res_cnt          <= res_push ? RC_W'(1) : '0;
        bus.res_overflow <= 1'b0;
      end else begin
        if (res_push) res_wr <= res_wr + RA_W'(1);
        if (res_take) res_rd <= res_rd + RA_W'(1);
        case ({res_push, res_take})
          2'b10:   res_cnt <= res_cnt + RC_W'(1);
          2'b01:   res_cnt <= res_cnt - RC_W'(1);
          default: ;
        endcase
        if (bus.core_success && !res_push) bus.res_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res_push) res_mem[bus.flush ? '0 : res_wr] <= {bus.core_hash_id, bus.core_nonce};
  end
endmodule

// File: tb/tb_ht_job_scheduler.sv
// Directed bench for ht_job_scheduler: dispatch latency, queue limits, result overflow,
// dispatch timeout, flush and asynchronous reset.
module tb_ht_job_scheduler;
  localparam int JOB_DEPTH = 4;
  localparam int RES_DEPTH = 8;
  localparam int ID_W      = 4;
  localparam int BUSY_TMO  = 15;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  ht_job_scheduler_if #(.JOB_DEPTH(JOB_DEPTH), .ID_W(ID_W)) bus ();

  ht_job_scheduler #(
    .JOB_DEPTH(JOB_DEPTH), .RES_DEPTH(RES_DEPTH), .ID_W(ID_W), .BUSY_TMO(BUSY_TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_job(input logic [3:0] id);
    bus.job_valid  = 1'b1;
    bus.job_id     = id;
    bus.job_m_data = {24{id}};
    bus.job_init_h = {64{id}};
    tick();
    bus.job_valid  = 1'b0;
  endtask

  task automatic wait_start(input string tag, input logic [3:0] exp_id);
    int n = 0;
    while (!bus.core_start && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_start"}, 64'(bus.core_start), 64'd1);
    check({tag, "_id"}, 64'(bus.core_id), 64'(exp_id));
  endtask

  // Called in the LAUNCH cycle: acknowledge with busy, then let the engine finish.
  task automatic finish_job();
    bus.core_busy = 1'b1;
    tick();
    tick();
    bus.core_busy = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int starts;
    bus.job_valid = 0; bus.job_id = '0; bus.job_m_data = '0; bus.job_init_h = '0;
    bus.core_busy = 0; bus.core_success = 0; bus.core_nonce = '0; bus.core_hash_id = '0;
    bus.res_pop = 0; bus.flush = 0;
    repeat (2) tick();
    check("rst_job_ready", 64'(bus.job_ready), 64'd1);
    check("rst_core_start", 64'(bus.core_start), 64'd0);
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_irq", 64'(bus.irq), 64'd0);
    check("rst_job_count", 64'(bus.job_count), 64'd0);
    check("rst_core_id", 64'(bus.core_id), 64'd0);
    check("rst_res_data", 64'(bus.res_data), 64'd0);
    reset_n = 1'b1;
    tick();

    // T1: single job latency and one result
    push_job(4'd3);
    check("t1_count", 64'(bus.job_count), 64'd1);
    check("t1_nostart", 64'(bus.core_start), 64'd0);
    tick();
    check("t1_start", 64'(bus.core_start), 64'd1);
    check("t1_core_id", 64'(bus.core_id), 64'd3);
    check("t1_mdata", bus.core_m_data[63:0], 64'h3333_3333_3333_3333);
    check("t1_count_pop", 64'(bus.job_count), 64'd0);
    bus.core_busy = 1'b1;
    tick();
    check("t1_pulse", 64'(bus.core_start), 64'd0);
    repeat (9) tick();
    bus.core_busy = 1'b0;
    bus.core_success = 1'b1; bus.core_nonce = 32'hDEADBEEF; bus.core_hash_id = 4'd3;
    tick();
    bus.core_success = 1'b0;
    check("t1_res_valid", 64'(bus.res_valid), 64'd1);
    check("t1_res_data", 64'(bus.res_data), 64'h3_DEAD_BEEF);
    check("t1_irq_lag", 64'(bus.irq), 64'd0);
    tick();
    check("t1_irq", 64'(bus.irq), 64'd1);
    bus.res_pop = 1'b1;
    tick();
    bus.res_pop = 1'b0;
    check("t1_popped", 64'(bus.res_valid), 64'd0);
    tick();
    check("t1_irq_clr", 64'(bus.irq), 64'd0);

    // T2: fill queue behind a running job; dispatch order
    push_job(4'd0);
    wait_start("t2_0", 4'd0);
    bus.core_busy = 1'b1;
    for (int i = 1; i <= 4; i++) push_job(4'(i));
    check("t2_count_full", 64'(bus.job_count), 64'd4);
    check("t2_ready_full", 64'(bus.job_ready), 64'd0);
    bus.job_valid = 1'b1; bus.job_id = 4'd9;
    tick();
    bus.job_valid = 1'b0;
    check("t2_refused", 64'(bus.job_count), 64'd4);
    for (int i = 1; i <= 4; i++) begin
      bus.core_busy = 1'b0;
      wait_start($sformatf("t2_%0d", i), 4'(i));
      check($sformatf("t2_count_%0d", i), 64'(bus.job_count), 64'(4 - i));
      bus.core_busy = 1'b1;
      tick();
      tick();
    end
    bus.core_busy = 1'b0;
    tick();
    tick();

    // T3: result overflow, then full-with-pop
    for (int i = 0; i < 9; i++) begin
      bus.core_success = 1'b1; bus.core_nonce = 32'(32'hA000_0000 + i); bus.core_hash_id = 4'(i);
      tick();
    end
    bus.core_success = 1'b0;
    check("t3_ovf", 64'(bus.res_overflow), 64'd1);
    bus.res_pop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t3_q%0d", i), 64'(bus.res_data), 64'({4'(i), 32'(32'hA000_0000 + i)}));
      tick();
    end
    bus.res_pop = 1'b0;
    check("t3_drained", 64'(bus.res_valid), 64'd0);
    check("t3_ovf_sticky", 64'(bus.res_overflow), 64'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("t3_ovf_flush", 64'(bus.res_overflow), 64'd0);
    for (int i = 0; i < 9; i++) begin
      bus.core_success = 1'b1; bus.core_nonce = 32'(32'hA000_0000 + i); bus.core_hash_id = 4'(i);
      bus.res_pop = (i == 8);
      tick();
    end
    bus.core_success = 1'b0;
    bus.res_pop = 1'b0;
    check("t3b_no_ovf", 64'(bus.res_overflow), 64'd0);
    bus.res_pop = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("t3b_q%0d", i), 64'(bus.res_data), 64'({4'(i), 32'(32'hA000_0000 + i)}));
      tick();
    end
    bus.res_pop = 1'b0;
    check("t3b_drained", 64'(bus.res_valid), 64'd0);

    // T4: dispatch timeout, next queued job launched
    push_job(4'd6);
    push_job(4'd7);
    wait_start("t4_a", 4'd6);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.dispatch_err && n < 40);
    check("t4_tmo_cycles", 64'(n), 64'd16);
    check("t4_err", 64'(bus.dispatch_err), 64'd1);
    check("t4_idle", 64'(bus.core_start), 64'd0);
    tick();
    check("t4_err_pulse", 64'(bus.dispatch_err), 64'd0);
    check("t4_next_start", 64'(bus.core_start), 64'd1);
    check("t4_next_id", 64'(bus.core_id), 64'd7);
    finish_job();

    // T5: flush while running with queued jobs and pending results
    push_job(4'd8);
    wait_start("t5", 4'd8);
    bus.core_busy = 1'b1;
    tick();
    tick();
    push_job(4'd9);
    push_job(4'd10);
    for (int i = 0; i < 9; i++) begin
      bus.core_success = 1'b1; bus.core_nonce = 32'(32'h5000_0000 + i); bus.core_hash_id = 4'(i);
      tick();
    end
    bus.core_success = 1'b0;
    bus.res_pop = 1'b1;
    repeat (5) tick();
    bus.res_pop = 1'b0;
    check("t5_pre_count", 64'(bus.job_count), 64'd2);
    check("t5_pre_ovf", 64'(bus.res_overflow), 64'd1);
    check("t5_pre_head", 64'(bus.res_data), 64'h5_5000_0005);
    bus.flush = 1'b1;
    bus.core_success = 1'b1; bus.core_nonce = 32'h5555_0005; bus.core_hash_id = 4'd8;
    bus.job_valid = 1'b1; bus.job_id = 4'd15;
    #1;
    check("t5_ready_flush", 64'(bus.job_ready), 64'd0);
    tick();
    bus.flush = 1'b0;
    bus.core_success = 1'b0;
    bus.job_valid = 1'b0;
    check("t5_count", 64'(bus.job_count), 64'd0);
    check("t5_res_valid", 64'(bus.res_valid), 64'd1);
    check("t5_res_data", 64'(bus.res_data), 64'h8_5555_0005);
    check("t5_ovf_clr", 64'(bus.res_overflow), 64'd0);
    bus.res_pop = 1'b1;
    tick();
    bus.res_pop = 1'b0;
    check("t5_one_result", 64'(bus.res_valid), 64'd0);
    push_job(4'd11);
    starts = 0;
    repeat (4) begin
      starts += int'(bus.core_start);
      tick();
    end
    check("t5_run_held", 64'(starts), 64'd0);
    check("t5_queued", 64'(bus.job_count), 64'd1);
    bus.core_busy = 1'b0;
    wait_start("t5_after", 4'd11);
    finish_job();

    // T6: asynchronous reset mid-run
    push_job(4'd12);
    wait_start("t6", 4'd12);
    bus.core_busy = 1'b1;
    tick();
    tick();
    bus.core_success = 1'b1; bus.core_nonce = 32'h1234_5678; bus.core_hash_id = 4'd12;
    tick();
    bus.core_success = 1'b0;
    push_job(4'd13);
    check("t6_pre_res", 64'(bus.res_valid), 64'd1);
    check("t6_pre_count", 64'(bus.job_count), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_res_valid", 64'(bus.res_valid), 64'd0);
    check("t6_res_data", 64'(bus.res_data), 64'd0);
    check("t6_irq", 64'(bus.irq), 64'd0);
    check("t6_job_count", 64'(bus.job_count), 64'd0);
    check("t6_core_id", 64'(bus.core_id), 64'd0);
    check("t6_core_init_h", bus.core_init_h[63:0], 64'd0);
    check("t6_core_start", 64'(bus.core_start), 64'd0);
    check("t6_ovf", 64'(bus.res_overflow), 64'd0);
    check("t6_err", 64'(bus.dispatch_err), 64'd0);
    check("t6_ready", 64'(bus.job_ready), 64'd1);
    tick();
    reset_n = 1'b1;
    bus.core_busy = 1'b0;
    tick();
    push_job(4'd14);
    wait_start("t6_resume", 4'd14);
    finish_job();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
